// File: rtl/sdram_line_reader.sv
// rtl/sdram_line_reader.sv - scan-line prefetcher and byte unpacker for the ip_sdram host bus

// Word FIFO between the bus side and the pixel unpacker; flush empties it in one cycle.
module sdram_line_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush discards everything that is stored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array carries no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// Fetches one line of words, queues them, and serves them byte by byte.
module sdram_line_reader #(
   parameter int LINE_WORDS = 320,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sdram_init_busy,
   input  logic        sdram_busy,
   output logic        mreq_n,
   output logic [22:0] address,
   output logic        wr_n,
   output logic        rd_n,
   output logic        rfsh_n,
   input  logic [31:0] rdata,
   input  logic        rdata_en,
   input  logic        line_start,
   input  logic [22:0] line_addr,
   input  logic        rfsh_req,
   input  logic        pix_rd,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   output logic        line_done,
   output logic        underrun
);
   localparam int WLW = $clog2(LINE_WORDS + 1);

   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_REQ  = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_RFSH = 3'd4;

   logic [2:0]     state;
   logic [20:0]    word_addr;
   logic [WLW-1:0] words_left;
   logic           rfsh_pend;
   logic           discard;

   logic           ls;
   logic           fifo_wr;
   logic           fifo_rd;
   logic           fifo_empty;
   logic           fifo_full;
   logic [31:0]    fifo_dout;

   logic [31:0]    cur_word;
   logic [1:0]     byte_idx;
   logic [31:0]    nxt_word;
   logic [1:0]     nxt_idx;
   logic           nxt_valid;
   logic [7:0]     nxt_pix;

   logic           unused_line_addr_lsbs;
   assign unused_line_addr_lsbs = ^line_addr[1:0];

   // line_start only has meaning once the controller is out of initialisation.
   assign ls = line_start && (state != ST_INIT);

   // A returned word is kept only if it belongs to the current line.
   assign fifo_wr = (state == ST_WAIT) && rdata_en && !discard && !ls;

   sdram_line_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (ls),
      .wr_en   (fifo_wr),
      .wr_data (rdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Bus-side FSM: issues one read or refresh at a time and tracks the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         word_addr  <= '0;
         words_left <= '0;
         rfsh_pend  <= 1'b0;
         discard    <= 1'b0;
         mreq_n     <= 1'b1;
         rd_n       <= 1'b1;
         rfsh_n     <= 1'b1;
         address    <= '0;
         line_done  <= 1'b0;
      end else begin
         line_done <= 1'b0;
         case (state)
            ST_INIT: begin
               if (!sdram_init_busy)
                  state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (rfsh_pend) begin
                  state  <= ST_RFSH;
                  mreq_n <= 1'b0;
                  rfsh_n <= 1'b0;
               end else if ((words_left != '0) && !fifo_full && !ls) begin
                  state   <= ST_REQ;
                  mreq_n  <= 1'b0;
                  rd_n    <= 1'b0;
                  address <= {word_addr, 2'b00};
               end
            end
            ST_REQ: begin
               // A new line during a pending read lets the read finish but marks it stale.
               if (ls)
                  discard <= 1'b1;
               if (!sdram_busy) begin
                  mreq_n <= 1'b1;
                  rd_n   <= 1'b1;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rdata_en) begin
                  state   <= ST_IDLE;
                  discard <= 1'b0;
                  if (!discard && !ls) begin
                     word_addr  <= word_addr + 1'b1;
                     words_left <= words_left - 1'b1;
                     if (words_left == WLW'(1))
                        line_done <= 1'b1;
                  end
               end else if (ls) begin
                  discard <= 1'b1;
               end
            end
            ST_RFSH: begin
               if (!sdram_busy) begin
                  mreq_n    <= 1'b1;
                  rfsh_n    <= 1'b1;
                  rfsh_pend <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               mreq_n <= 1'b1;
               rd_n   <= 1'b1;
               rfsh_n <= 1'b1;
            end
         endcase
         // New line parameters override any update made by the completing read.
         if (ls) begin
            word_addr  <= line_addr[22:2];
            words_left <= WLW'(LINE_WORDS);
         end
         // A request arriving at the acceptance edge is a fresh one and stays pending.
         if (rfsh_req)
            rfsh_pend <= 1'b1;
      end
   end

   // Write strobe is never used by this reader.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wr_n <= 1'b1;
      else
         wr_n <= 1'b1;
   end

   // Unpacker next state: advance the byte index and reload from the FIFO without a bubble.
   always_comb begin
      nxt_word  = cur_word;
      nxt_idx   = byte_idx;
      nxt_valid = pix_valid;
      fifo_rd   = 1'b0;
      if (ls) begin
         nxt_valid = 1'b0;
         nxt_idx   = 2'd0;
      end else if (pix_valid && pix_rd) begin
         if (byte_idx == 2'd3) begin
            nxt_idx = 2'd0;
            if (!fifo_empty) begin
               fifo_rd   = 1'b1;
               nxt_word  = fifo_dout;
               nxt_valid = 1'b1;
            end else begin
               nxt_valid = 1'b0;
            end
         end else begin
            nxt_idx = byte_idx + 2'd1;
         end
      end else if (!pix_valid && !fifo_empty) begin
         fifo_rd   = 1'b1;
         nxt_word  = fifo_dout;
         nxt_idx   = 2'd0;
         nxt_valid = 1'b1;
      end
   end

   // Byte lane selection for the registered pixel output.
   always_comb begin
      nxt_pix = nxt_word[7:0];
      case (nxt_idx)
         2'd0: nxt_pix = nxt_word[7:0];
         2'd1: nxt_pix = nxt_word[15:8];
         2'd2: nxt_pix = nxt_word[23:16];
         2'd3: nxt_pix = nxt_word[31:24];
         default: nxt_pix = nxt_word[7:0];
      endcase
   end

   // Unpacker registers and the sticky underrun flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_word  <= '0;
         byte_idx  <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
         underrun  <= 1'b0;
      end else begin
         cur_word  <= nxt_word;
         byte_idx  <= nxt_idx;
         pix_valid <= nxt_valid;
         pix_data  <= nxt_pix;
         if (ls)
            underrun <= 1'b0;
         else if (pix_rd && !pix_valid)
            underrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdram_line_reader.sv
// tb/tb_sdram_line_reader.sv - directed bench for sdram_line_reader with a small SDRAM responder
`timescale 1ns/1ps
module tb_sdram_line_reader;
   logic        clk = 1'b0;
   logic        reset;
   logic        sdram_init_busy;
   logic        sdram_busy;
   logic        mreq_n;
   logic [22:0] address;
   logic        wr_n;
   logic        rd_n;
   logic        rfsh_n;
   logic [31:0] rdata = '0;
   logic        rdata_en = 1'b0;
   logic        line_start;
   logic [22:0] line_addr;
   logic        rfsh_req;
   logic        pix_rd;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        line_done;
   logic        underrun;

   int vectors = 0;
   int miscompares = 0;

   int          acc_cnt = 0;
   int          ld_cnt = 0;
   int          rd_cnt = 0;
   logic [22:0] rd_addr = '0;
   int          log_n = 0;
   int          log_op [64];
   logic [22:0] log_addr [64];

   logic [7:0]  exp_a [8] = '{8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89};

   sdram_line_reader #(
      .LINE_WORDS (2),
      .FIFO_DEPTH (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .sdram_init_busy (sdram_init_busy),
      .sdram_busy      (sdram_busy),
      .mreq_n          (mreq_n),
      .address         (address),
      .wr_n            (wr_n),
      .rd_n            (rd_n),
      .rfsh_n          (rfsh_n),
      .rdata           (rdata),
      .rdata_en        (rdata_en),
      .line_start      (line_start),
      .line_addr       (line_addr),
      .rfsh_req        (rfsh_req),
      .pix_rd          (pix_rd),
      .pix_data        (pix_data),
      .pix_valid       (pix_valid),
      .line_done       (line_done),
      .underrun        (underrun)
   );

   always #5 clk = ~clk;

   // Memory image: two fixed words at 0 and 4, elsewhere bytes count up from addr[9:2].
   function automatic logic [31:0] mem_word(input logic [22:0] a);
      logic [7:0] b;
      b = a[9:2];
      case (a)
         23'h000000: return 32'h45342312;
         23'h000004: return 32'h89786756;
         default:    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
      endcase
   endfunction

   // SDRAM responder: accepts on a non-busy edge, returns read data three edges later, logs ops.
   always @(posedge clk) begin
      rdata_en <= 1'b0;
      if (line_done === 1'b1)
         ld_cnt <= ld_cnt + 1;
      if (rd_cnt != 0) begin
         rd_cnt <= rd_cnt - 1;
         if (rd_cnt == 1) begin
            rdata_en <= 1'b1;
            rdata    <= mem_word(rd_addr);
         end
      end
      if (reset === 1'b0 && mreq_n === 1'b0 && sdram_busy === 1'b0) begin
         acc_cnt <= acc_cnt + 1;
         if (log_n < 64) begin
            log_addr[log_n] <= address;
            log_op[log_n]   <= (rd_n === 1'b0 && rfsh_n === 1'b1) ? 1 :
                               (rd_n === 1'b1 && rfsh_n === 1'b0) ? 2 : 3;
            log_n <= log_n + 1;
         end
         if (rd_n === 1'b0) begin
            rd_cnt  <= 3;
            rd_addr <= address;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_line(input logic [22:0] a);
      line_addr  = a;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic wait_done(input int ld0, input string tag);
      for (int k = 0; k < 300 && ld_cnt == ld0; k++)
         tick();
      check(tag, ld_cnt - ld0, 1);
   endtask

   task automatic wait_accept_read(input string tag);
      for (int k = 0; k < 100 && mreq_n !== 1'b0; k++)
         tick();
      for (int k = 0; k < 100 && mreq_n !== 1'b1; k++)
         tick();
      check(tag, {31'd0, mreq_n}, 1);
   endtask

   task automatic pop(input int n);
      pix_rd = 1'b1;
      repeat (n) tick();
      pix_rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, ld0, a0, bad;
      logic [22:0] addr0;
      reset = 1'b1; sdram_init_busy = 1'b1; sdram_busy = 1'b0;
      line_start = 1'b0; line_addr = '0; rfsh_req = 1'b0; pix_rd = 1'b0;
      @(negedge clk);
      tick(); tick();

      // Reset values
      check("rst_mreq_n", {31'd0, mreq_n}, 1);
      check("rst_rd_n", {31'd0, rd_n}, 1);
      check("rst_wr_n", {31'd0, wr_n}, 1);
      check("rst_rfsh_n", {31'd0, rfsh_n}, 1);
      check("rst_address", {9'd0, address}, 0);
      check("rst_pix_data", {24'd0, pix_data}, 0);
      check("rst_pix_valid", {31'd0, pix_valid}, 0);
      check("rst_line_done", {31'd0, line_done}, 0);
      check("rst_underrun", {31'd0, underrun}, 0);

      // Initialisation: a refresh requested during INIT must wait until init_busy falls
      reset = 1'b0;
      rfsh_req = 1'b1; tick(); rfsh_req = 1'b0;
      bad = 0;
      repeat (50) begin
         if (mreq_n !== 1'b1) bad++;
         tick();
      end
      check("init_no_request", bad, 0);
      check("init_no_accept", log_n, 0);
      sdram_init_busy = 1'b0;
      repeat (6) tick();
      check("init_rfsh_after", log_n, 1);
      check("init_rfsh_op", log_op[0], 2);

      // Basic line of two words at address 0, pixels drained back to back
      l0 = log_n; ld0 = ld_cnt;
      start_line(23'h000000);
      wait_done(ld0, "a_line_done");
      repeat (3) tick();
      pix_rd = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (pix_valid !== 1'b1 || pix_data !== exp_a[i]) bad++;
         tick();
      end
      check("a_pix_seq_errors", bad, 0);
      check("a_pix_valid_end", {31'd0, pix_valid}, 0);
      pix_rd = 1'b0;
      repeat (5) tick();
      check("a_line_done_once", ld_cnt - ld0, 1);
      check("a_reads", log_n - l0, 2);
      check("a_addr0", {9'd0, log_addr[l0]}, 32'h0);
      check("a_addr1", {9'd0, log_addr[l0 + 1]}, 32'h4);
      check("a_underrun", {31'd0, underrun}, 0);

      // Busy held for 10 cycles during REQ
      l0 = log_n; ld0 = ld_cnt;
      sdram_busy = 1'b1;
      start_line(23'h000200);
      for (int k = 0; k < 20 && mreq_n !== 1'b0; k++)
         tick();
      addr0 = address;
      a0 = acc_cnt;
      check("b_req_addr", {9'd0, addr0}, 32'h200);
      bad = 0;
      repeat (10) begin
         if (mreq_n !== 1'b0 || rd_n !== 1'b0 || rfsh_n !== 1'b1 || address !== addr0) bad++;
         tick();
      end
      check("b_stable_errors", bad, 0);
      check("b_no_accept_busy", acc_cnt - a0, 0);
      sdram_busy = 1'b0;
      tick();
      check("b_strobe_release", {31'd0, mreq_n}, 1);
      check("b_one_accept", acc_cnt - a0, 1);
      wait_done(ld0, "b_line_done");
      repeat (3) tick();
      check("b_reads", log_n - l0, 2);
      check("b_pix0", {24'd0, pix_data}, 32'h80);
      pop(4);
      check("b_pix4", {24'd0, pix_data}, 32'h81);
      pop(4);
      check("b_two_words_only", {31'd0, pix_valid}, 0);

      // Two refresh requests during WAIT merge into one, between the two reads
      l0 = log_n; ld0 = ld_cnt;
      start_line(23'h000300);
      wait_accept_read("c_first_accept");
      rfsh_req = 1'b1; tick(); rfsh_req = 1'b0; tick();
      rfsh_req = 1'b1; tick(); rfsh_req = 1'b0;
      wait_done(ld0, "c_line_done");
      repeat (4) tick();
      check("c_ops", log_n - l0, 3);
      check("c_op0_read", log_op[l0], 1);
      check("c_op1_rfsh", log_op[l0 + 1], 2);
      check("c_op2_read", log_op[l0 + 2], 1);
      check("c_op2_addr", {9'd0, log_addr[l0 + 2]}, 32'h304);

      // line_start during WAIT discards the old word and clears underrun
      l0 = log_n; ld0 = ld_cnt;
      start_line(23'h000000);
      pix_rd = 1'b1; tick(); pix_rd = 1'b0;
      check("d_underrun_set", {31'd0, underrun}, 1);
      wait_accept_read("d_first_accept");
      start_line(23'h000100);
      check("d_underrun_clear", {31'd0, underrun}, 0);
      wait_done(ld0, "d_line_done");
      repeat (4) tick();
      check("d_pix0", {24'd0, pix_data}, 32'h40);
      check("d_ops", log_n - l0, 3);
      check("d_addr1", {9'd0, log_addr[l0 + 1]}, 32'h100);
      check("d_done_once", ld_cnt - ld0, 1);

      // line_start coinciding with rdata_en discards the returned word
      l0 = log_n; ld0 = ld_cnt;
      start_line(23'h000200);
      for (int k = 0; k < 50 && rdata_en !== 1'b1; k++)
         tick();
      check("f_rdata_seen", {31'd0, rdata_en}, 1);
      start_line(23'h000100);
      wait_done(ld0, "f_line_done");
      repeat (3) tick();
      check("f_pix0", {24'd0, pix_data}, 32'h40);
      pop(8);
      check("f_two_words_only", {31'd0, pix_valid}, 0);
      check("f_ops", log_n - l0, 3);

      // Sticky underrun and word address wrap at the top of memory
      l0 = log_n; ld0 = ld_cnt;
      start_line(23'h7FFFFC);
      pix_rd = 1'b1; tick(); pix_rd = 1'b0;
      check("e_underrun_set", {31'd0, underrun}, 1);
      wait_done(ld0, "e_line_done");
      repeat (3) tick();
      check("e_underrun_sticky", {31'd0, underrun}, 1);
      check("e_addr0", {9'd0, log_addr[l0]}, 32'h7FFFFC);
      check("e_addr1", {9'd0, log_addr[l0 + 1]}, 32'h000000);
      check("e_pix0", {24'd0, pix_data}, 32'hFF);
      pop(4);
      check("e_pix4", {24'd0, pix_data}, 32'h12);
      check("e_underrun_still", {31'd0, underrun}, 1);
      start_line(23'h000400);
      check("e_underrun_cleared", {31'd0, underrun}, 0);
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
